// File: rtl/user_cq_merge_if.sv
// user_cq_merge_if: valid/ready/data completion stream.
// The master drives valid and data. The slave drives ready.
interface user_cq_merge_if #(
  parameter int DATA_BITS = 32
);
  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/user_cq_merge.sv
// user_cq_merge: merges completion streams into one registered output stage.
// The sources are taken in round-robin order. The block also keeps read and
// write outstanding counters, which saturate and drive stall flags, and a
// sticky underflow flag.
//
// Build option: define USER_CQ_REMOTE_EN to add the two remote completion
// sources. Source order is local_rd, local_wr, remote_rd, remote_wr. Without
// the macro, only the two local sources exist, and the output src field is
// only ever 0 or 1.
//
// Output entry layout: {vfid, src[1:0], wr, rsvd, payload}.
module user_cq_merge #(
  parameter int CQ_BITS   = 32,
  parameter int OUT_BITS  = 8,
  parameter int ID_REG    = 0,
  parameter int VFID_BITS = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                issue_rd,
  input  logic                issue_wr,
  user_cq_merge_if.slave      s_local_rd_cq,
  user_cq_merge_if.slave      s_local_wr_cq,
`ifdef USER_CQ_REMOTE_EN
  user_cq_merge_if.slave      s_remote_rd_cq,
  user_cq_merge_if.slave      s_remote_wr_cq,
`endif
  user_cq_merge_if.master     m_user_cq,
  output logic [OUT_BITS-1:0] rd_outstanding,
  output logic [OUT_BITS-1:0] wr_outstanding,
  output logic                sq_rd_stall,
  output logic                sq_wr_stall,
  output logic                err_underflow
);

`ifdef USER_CQ_REMOTE_EN
  localparam int N = 4;
`else
  localparam int N = 2;
`endif
  localparam int                  OUT_W    = VFID_BITS + 4 + CQ_BITS;
  localparam logic [1:0]          IDX_MASK = 2'(N - 1);
  localparam logic [1:0]          LAST_IDX = 2'(N - 1);
  localparam logic [OUT_BITS-1:0] CNT_MAX  = '1;

  // Reset is asserted asynchronously. Its release passes through two flops.
  logic [1:0] rst_sync_q;
  logic       run_n;

  // Source view. This is always four entries wide, so a 2-bit index can
  // select from it. Sources that are not built read as idle.
  logic [3:0]         src_valid;
  logic [CQ_BITS-1:0] src_data [4];
  logic [N-1:0]       src_ready;

  // Arbitration.
  logic [1:0] last_grant_q, last_grant_d;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic       grant_hit;
  logic       can_load;
  logic       accept;
  logic       rd_dec, wr_dec;

  // Output stage and counters.
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic [OUT_BITS-1:0] rd_cnt_q, rd_cnt_d;
  logic [OUT_BITS-1:0] wr_cnt_q, wr_cnt_d;
  logic                err_q, err_d;
  logic [OUT_BITS:0]   rd_step, wr_step;

  // Advances a saturating counter by one issue pulse and one completion.
  // The result is {underflow, next}. An issue and a completion in the same
  // cycle cancel. A completion at zero holds the count at zero and flags
  // underflow.
  function automatic logic [OUT_BITS:0] cnt_step(input logic [OUT_BITS-1:0] cnt,
                                                 input logic inc, input logic dec);
    logic [OUT_BITS-1:0] nxt;
    logic                uf;
    nxt = cnt;
    uf  = 1'b0;
    if (inc && !dec) begin
      if (cnt != CNT_MAX) nxt = cnt + OUT_BITS'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) uf  = 1'b1;
      else           nxt = cnt - OUT_BITS'(1);
    end
    return {uf, nxt};
  endfunction

  // Deassertion of aresetn is seen only on an aclk edge. Assertion takes effect at once.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run_n = rst_sync_q[1];

  assign src_valid[0] = s_local_rd_cq.valid;
  assign src_valid[1] = s_local_wr_cq.valid;
  assign src_data[0]  = s_local_rd_cq.data;
  assign src_data[1]  = s_local_wr_cq.data;
  assign s_local_rd_cq.ready = src_ready[0];
  assign s_local_wr_cq.ready = src_ready[1];
`ifdef USER_CQ_REMOTE_EN
  assign src_valid[2] = s_remote_rd_cq.valid;
  assign src_valid[3] = s_remote_wr_cq.valid;
  assign src_data[2]  = s_remote_rd_cq.data;
  assign src_data[3]  = s_remote_wr_cq.data;
  assign s_remote_rd_cq.ready = src_ready[2];
  assign s_remote_wr_cq.ready = src_ready[3];
`else
  assign src_valid[3:2] = 2'b00;
  assign src_data[2]    = '0;
  assign src_data[3]    = '0;
`endif

  // Round-robin pick: the first valid source after last_grant.
  // If no source is valid, the slot after last_grant is offered.
  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    grant_idx = (last_grant_q + 2'd1) & IDX_MASK;
    grant_hit = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (last_grant_q + 2'(k)) & IDX_MASK;
      if (!grant_hit && src_valid[cand]) begin
        grant_idx = cand;
        grant_hit = 1'b1;
      end
    end
  end

  assign can_load = !out_valid_q || m_user_cq.ready;
  assign accept   = run_n && can_load && grant_hit;
  assign rd_dec   = accept && !grant_idx[0];
  assign wr_dec   = accept &&  grant_idx[0];

  // Exactly one ready, for the granted slot, while the output stage can load.
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < N; i++) begin
      src_ready[i] = run_n && can_load && (grant_idx == 2'(i));
    end
  end

  // Next state for the output stage, the arbiter pointer and the counters.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = {VFID_BITS'(ID_REG), grant_idx, grant_idx[0], 1'b0, src_data[grant_idx]};
      last_grant_d = grant_idx;
    end else if (m_user_cq.ready) begin
      out_valid_d  = 1'b0;
    end
    rd_step  = cnt_step(rd_cnt_q, issue_rd, rd_dec);
    wr_step  = cnt_step(wr_cnt_q, issue_wr, wr_dec);
    rd_cnt_d = rd_step[OUT_BITS-1:0];
    wr_cnt_d = wr_step[OUT_BITS-1:0];
    err_d    = err_q | rd_step[OUT_BITS] | wr_step[OUT_BITS];
  end

  // State registers. The internal reset follows aresetn down at once.
  // NOTE: the payload register is reset too, so the output never shows X after reset.
  always_ff @(posedge aclk or negedge run_n) begin
    if (!run_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      last_grant_q <= LAST_IDX;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      last_grant_q <= last_grant_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      err_q        <= err_d;
    end
  end

  assign m_user_cq.valid = out_valid_q;
  assign m_user_cq.data  = out_data_q;
  assign rd_outstanding  = rd_cnt_q;
  assign wr_outstanding  = wr_cnt_q;
  assign sq_rd_stall     = (rd_cnt_q == CNT_MAX);
  assign sq_wr_stall     = (wr_cnt_q == CNT_MAX);
  assign err_underflow   = err_q;

endmodule

// File: tb/tb_user_cq_merge.sv
// tb_user_cq_merge: randomized and directed stimulus for user_cq_merge.
// A behavioural model tracks the expected output entry, the expected readies,
// the counters and the underflow flag from the block's rules, and is compared
// every cycle. Directed sequences add hand-computed literal expectations.
`timescale 1ns/1ps
module tb_user_cq_merge;
`ifdef USER_CQ_REMOTE_EN
  localparam int NSRC = 4;
`else
  localparam int NSRC = 2;
`endif
  localparam int         CQ_BITS   = 32;
  localparam int         OUT_BITS  = 2;
  localparam int         ID_REG    = 5;
  localparam int         VFID_BITS = 4;
  localparam int         OW        = CQ_BITS + 4 + VFID_BITS;
  localparam int         CNT_MAX   = 3;
  localparam logic [3:0] VMASK     = 4'((1 << NSRC) - 1);

  logic aclk     = 1'b0;
  logic aresetn  = 1'b1;
  logic issue_rd = 1'b0;
  logic issue_wr = 1'b0;
  logic m_rdy    = 1'b0;
  logic [3:0]         v_drv = '0;
  logic [CQ_BITS-1:0] d_drv [4];
  logic [3:0]         rdy_mon;
  logic [OUT_BITS-1:0] rd_out, wr_out;
  logic rd_stall, wr_stall, err_uf;

  int n_checks = 0;
  int n_err    = 0;
  int dead_cnt = 0;
  bit model_run = 1'b0;

  always #5 aclk = ~aclk;

  user_cq_merge_if #(.DATA_BITS(CQ_BITS)) lrd_if ();
  user_cq_merge_if #(.DATA_BITS(CQ_BITS)) lwr_if ();
`ifdef USER_CQ_REMOTE_EN
  user_cq_merge_if #(.DATA_BITS(CQ_BITS)) rrd_if ();
  user_cq_merge_if #(.DATA_BITS(CQ_BITS)) rwr_if ();
`endif
  user_cq_merge_if #(.DATA_BITS(OW)) out_if ();

  assign lrd_if.valid = v_drv[0];
  assign lrd_if.data  = d_drv[0];
  assign lwr_if.valid = v_drv[1];
  assign lwr_if.data  = d_drv[1];
`ifdef USER_CQ_REMOTE_EN
  assign rrd_if.valid = v_drv[2];
  assign rrd_if.data  = d_drv[2];
  assign rwr_if.valid = v_drv[3];
  assign rwr_if.data  = d_drv[3];
  assign rdy_mon = {rwr_if.ready, rrd_if.ready, lwr_if.ready, lrd_if.ready};
`else
  assign rdy_mon = {2'b00, lwr_if.ready, lrd_if.ready};
`endif
  assign out_if.ready = m_rdy;

  user_cq_merge #(
    .CQ_BITS(CQ_BITS), .OUT_BITS(OUT_BITS), .ID_REG(ID_REG), .VFID_BITS(VFID_BITS)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .issue_rd(issue_rd),
    .issue_wr(issue_wr),
    .s_local_rd_cq(lrd_if),
    .s_local_wr_cq(lwr_if),
`ifdef USER_CQ_REMOTE_EN
    .s_remote_rd_cq(rrd_if),
    .s_remote_wr_cq(rwr_if),
`endif
    .m_user_cq(out_if),
    .rd_outstanding(rd_out),
    .wr_outstanding(wr_out),
    .sq_rd_stall(rd_stall),
    .sq_wr_stall(wr_stall),
    .err_underflow(err_uf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit               m_vld;
  logic [OW-1:0]    m_dat;
  int               ptr, rd_c, wr_c;
  bit               err_m;
  int               win, nr, nw;
  bit               take, uf;
  logic [3:0]       exp_rdy;

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 1; k <= NSRC; k++) begin
      if (v[(p + k) % NSRC]) return (p + k) % NSRC;
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] entry(input int s, input logic [CQ_BITS-1:0] d);
    return {4'(ID_REG), 2'(s), 1'(s % 2), 1'b0, d};
  endfunction

  always_comb begin
    win     = pick(v_drv, ptr);
    exp_rdy = '0;
    take    = 1'b0;
    uf      = 1'b0;
    if (!m_vld || m_rdy) begin
      exp_rdy[(win >= 0) ? win : (ptr + 1) % NSRC] = 1'b1;
      take = (win >= 0);
    end
    nr = rd_c + int'(issue_rd) - int'(take && (win % 2 == 0));
    nw = wr_c + int'(issue_wr) - int'(take && (win % 2 == 1));
    if (nr < 0) begin nr = 0; uf = 1'b1; end
    if (nw < 0) begin nw = 0; uf = 1'b1; end
    if (nr > CNT_MAX) nr = CNT_MAX;
    if (nw > CNT_MAX) nw = CNT_MAX;
  end

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_vld <= 1'b0;
      m_dat <= '0;
      ptr   <= NSRC - 1;
      rd_c  <= 0;
      wr_c  <= 0;
      err_m <= 1'b0;
    end else if (model_run) begin
      if (take) begin
        m_vld <= 1'b1;
        m_dat <= entry(win, d_drv[win]);
        ptr   <= win;
      end else if (m_rdy) begin
        m_vld <= 1'b0;
      end
      rd_c <= nr;
      wr_c <= nw;
      if (uf) err_m <= 1'b1;
    end
  end

  // Compare process: runs on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge aclk);
      if (model_run && aresetn) begin
        check("m_valid", out_if.valid, m_vld);
        if (m_vld) check("m_data", out_if.data, m_dat);
        check("s_ready", rdy_mon, exp_rdy);
        check("rd_outstanding", rd_out, rd_c);
        check("wr_outstanding", wr_out, wr_c);
        check("sq_rd_stall", rd_stall, rd_c == CNT_MAX);
        check("sq_wr_stall", wr_stall, wr_c == CNT_MAX);
        check("err_underflow", err_uf, err_m);
        if (out_if.valid && m_rdy && out_if.data[31:0] == 32'hDEADBEEF) dead_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic idle();
    v_drv    = '0;
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    m_rdy    = 1'b0;
    for (int i = 0; i < 4; i++) d_drv[i] = '0;
  endtask

  task automatic do_reset();
    model_run = 1'b0;
    aresetn   = 1'b0;
    #1;
    check("rst_valid", out_if.valid, 0);
    check("rst_ready", rdy_mon, 0);
    check("rst_rd_cnt", rd_out, 0);
    check("rst_wr_cnt", wr_out, 0);
    check("rst_stalls", {rd_stall, wr_stall}, 0);
    check("rst_err", err_uf, 0);
    idle();
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    repeat (4) tick();
    model_run = 1'b1;
  endtask

  initial begin
    idle();
    #1;
    do_reset();

    // Underflow: a completion with nothing outstanding is still forwarded.
    v_drv[0] = 1'b1; d_drv[0] = 32'h0000_1234; m_rdy = 1'b1;
    tick();
    check("uf_err", err_uf, 1);
    check("uf_cnt", rd_out, 0);
    check("uf_valid", out_if.valid, 1);
    check("uf_fwd", out_if.data, 40'h50_0000_1234);
    v_drv[0] = 1'b0;
    tick(); tick();
    check("uf_sticky", err_uf, 1);

    // Saturation with OUT_BITS = 2, then cancelling issue and completion.
    do_reset();
    check("rst_clears_err", err_uf, 0);
    issue_rd = 1'b1;
    tick();
    check("sat_rd1", rd_out, 1);
    tick(); tick();
    check("sat_rd3", rd_out, 3);
    check("sat_stall", rd_stall, 1);
    tick();
    check("sat_hold", rd_out, 3);
    issue_rd = 1'b0; v_drv[0] = 1'b1; d_drv[0] = 32'h0000_0042; m_rdy = 1'b1;
    tick();
    check("sat_dec", rd_out, 2);
    check("sat_unstall", rd_stall, 0);
    v_drv[0] = 1'b0; issue_wr = 1'b1;
    tick();
    check("wr_inc", wr_out, 1);
    v_drv[1] = 1'b1; d_drv[1] = 32'h0000_0077;
    tick();
    check("wr_cancel", wr_out, 1);
    issue_wr = 1'b0; v_drv[1] = 1'b0;
    tick();

    // Hold the output while m_user_cq.ready is low.
    m_rdy = 1'b0; v_drv[0] = 1'b1; d_drv[0] = 32'hDEADBEEF; dead_cnt = 0;
    tick();
    v_drv[0] = 1'b0; v_drv[1] = 1'b1; d_drv[1] = 32'h1111_1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold_valid", out_if.valid, 1);
      check("hold_data", out_if.data, 40'h50_DEAD_BEEF);
      check("hold_ready", rdy_mon, 0);
    end
    m_rdy = 1'b1;
    tick();
    check("after_hold_data", out_if.data, 40'h56_1111_1111);
    v_drv[1] = 1'b0;
    tick(); tick();
    check("dead_once", dead_cnt, 1);

    // Round robin with every source valid and the sink always ready.
    do_reset();
    for (int i = 0; i < NSRC; i++) begin
      v_drv[i] = 1'b1;
      d_drv[i] = 32'hA000_0000 + 32'(i);
    end
    m_rdy = 1'b1;
    #1;
    check("rr_pre", out_if.valid, 0);
    for (int k = 0; k < 2 * NSRC; k++) begin
      tick();
      check("rr_valid", out_if.valid, 1);
      check("rr_src", out_if.data[35:34], k % NSRC);
      if (k == 0) check("rr_first", out_if.data, 40'h50_A000_0000);
      if (k == 1) check("rr_second", out_if.data, 40'h56_A000_0001);
    end
    v_drv = '0;
    tick(); tick();

    // Random traffic. The first half favours issues, the second half favours completions.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c < 1500) begin
        v_drv    = 4'($urandom) & 4'($urandom) & VMASK;
        issue_rd = ($urandom_range(0, 1) == 0);
        issue_wr = ($urandom_range(0, 1) == 0);
      end else begin
        v_drv    = 4'($urandom) & VMASK;
        issue_rd = ($urandom_range(0, 3) == 0);
        issue_wr = ($urandom_range(0, 3) == 0);
      end
      for (int i = 0; i < 4; i++) d_drv[i] = $urandom;
      m_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reset while the output is stalled: the held entry is dropped.
    idle();
    v_drv[0] = 1'b1; d_drv[0] = 32'hCAFE_0001;
    tick();
    v_drv[0] = 1'b0;
    tick();
    check("stall_before_rst", out_if.valid, 1);
    do_reset();
    m_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("no_emit_after_rst", out_if.valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
